// File: rtl/div_pkg.sv
// Shared types and constants for the divided-clock monitor.
package div_pkg;
  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_e;

  localparam int CNT_W   = 5;
  localparam int PHASE_W = 3;
  localparam logic [CNT_W-1:0] CNT_SAT = 5'd31;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? CNT_SAT : v + 1'b1;
  endfunction
endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit, synchronous reset to 0.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] s_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) s_q <= '0;
    else       s_q <= {s_q[STAGES-2:0], d_i};
  end

  assign q_o = s_q[STAGES-1];
endmodule

// File: rtl/div_clk_monitor.sv
// Samples a divided clock in the fast domain: rise strobe, phase flywheel,
// period measurement and lock tracking against the expected ratio.
module div_clk_monitor
  import div_pkg::*;
#(
  parameter int DIV_VAL     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 8
) (
  input  logic               in_clk,
  input  logic               in_rst,
  input  logic               div_clk_in,
  output logic               out_strobe,
  output logic [PHASE_W-1:0] out_phase,
  output logic [CNT_W-1:0]   out_period,
  output logic               out_lock,
  output logic               out_err
);
  localparam logic [CNT_W-1:0]   DIV_C   = CNT_W'(DIV_VAL);
  localparam logic [CNT_W-1:0]   TOUT_M1 = CNT_W'(2 * DIV_VAL - 1);
  localparam logic [PHASE_W-1:0] PH_MAX  = PHASE_W'(DIV_VAL - 1);
  localparam logic [3:0]         LOCK_C  = 4'(LOCK_CNT);

  logic               s_last;
  logic               prev_q, strobe_q, err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, period_q, period_d, meas;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [3:0]         good_q, good_d, good_inc;
  state_e             state_q, state_d;
  logic               rise, timeout;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i (in_clk),
    .rst_i (in_rst),
    .d_i   (div_clk_in),
    .q_o   (s_last)
  );

  assign rise     = s_last & ~prev_q;
  assign meas     = sat_inc(cnt_q);
  assign good_inc = good_q + 4'd1;
  // The cycle that would bring cnt to 2*DIV_VAL; a coincident rise takes precedence.
  assign timeout  = (cnt_q == TOUT_M1) && !rise;

  always_comb begin
    cnt_d    = rise ? '0 : meas;
    period_d = rise ? meas : period_q;
    if (rise || phase_q == PH_MAX) phase_d = '0;
    else                           phase_d = phase_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = 1'b0;
    case (state_q)
      HUNT: begin
        if (rise) begin
          state_d = CHECK;
          good_d  = '0;
        end
      end
      CHECK: begin
        if (rise) begin
          if (meas == DIV_C) begin
            good_d = good_inc;
            if (good_inc == LOCK_C) state_d = LOCKED;
          end else begin
            good_d = '0;
          end
        end else if (timeout) begin
          state_d = HUNT;
        end
      end
      LOCKED: begin
        if (rise) begin
          if (meas != DIV_C) begin
            err_d   = 1'b1;
            state_d = CHECK;
            good_d  = '0;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      prev_q   <= 1'b0;
      strobe_q <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      phase_q  <= '0;
      good_q   <= '0;
      err_q    <= 1'b0;
      state_q  <= HUNT;
    end else begin
      prev_q   <= s_last;
      strobe_q <= rise;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      phase_q  <= phase_d;
      good_q   <= good_d;
      err_q    <= err_d;
      state_q  <= state_d;
    end
  end

  assign out_strobe = strobe_q;
  assign out_phase  = phase_q;
  assign out_period = period_q;
  assign out_lock   = (state_q == LOCKED);
  assign out_err    = err_q;
endmodule

// File: tb/tb_div_clk_monitor.sv
// Bench for div_clk_monitor: edge-level lock model feeding a strobe/timeout scoreboard.
module tb_div_clk_monitor;
  import div_pkg::*;

  localparam int DIV  = 4;
  localparam int SYNC = 2;
  localparam int LCK  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       in_rst, div_in, div8;
  logic       strobe, lock, err, strobe8, lock8, err8;
  logic [2:0] phase, phase8;
  logic [4:0] period, period8;

  div_clk_monitor #(.DIV_VAL(DIV), .SYNC_STAGES(SYNC), .LOCK_CNT(LCK)) dut (
    .in_clk(clk), .in_rst(in_rst), .div_clk_in(div_in),
    .out_strobe(strobe), .out_phase(phase), .out_period(period),
    .out_lock(lock), .out_err(err)
  );

  div_clk_monitor #(.DIV_VAL(8), .SYNC_STAGES(2), .LOCK_CNT(8)) dut8 (
    .in_clk(clk), .in_rst(in_rst), .div_clk_in(div8),
    .out_strobe(strobe8), .out_phase(phase8), .out_period(period8),
    .out_lock(lock8), .out_err(err8)
  );

  typedef struct {int due; int period; bit lock; bit err;} exp_t;
  typedef struct {int due; bit err;} tout_t;
  typedef struct {int hi; int per; int reps; bit lock; bit err;} seg_t;

  exp_t  sq[$];
  tout_t tq[$];
  int checks = 0, errors = 0, cyc = 0;
  int err_pulses = 0, strobes = 0;
  bit rst_at_edge;

  state_e m_state = HUNT;
  int     m_good = 0, last_e = 0;
  bit     have_last = 1'b0, last_d = 1'b0, last_r = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle's inputs and update the edge-level expectation model.
  task automatic step(input bit d, input bit r, input bit d8);
    int   e, per;
    bit   rise;
    exp_t x;
    @(negedge clk);
    div_in = d;
    in_rst = r;
    div8   = d8;
    e = cyc + 1;
    if (r) begin
      sq.delete();
      tq.delete();
      m_state   = HUNT;
      m_good    = 0;
      have_last = 1'b0;
    end else begin
      rise = d && (!last_d || last_r);
      if (!rise && have_last && m_state != HUNT && e == last_e + 2*DIV + 1) begin
        tq.push_back('{due: last_e + SYNC + 2*DIV, err: (m_state == LOCKED)});
        m_state = HUNT;
      end
      if (rise) begin
        per = have_last ? ((e - last_e > 31) ? 31 : e - last_e) : -1;
        x.due = e + SYNC;
        x.period = per;
        x.err = 1'b0;
        case (m_state)
          HUNT: begin m_state = CHECK; m_good = 0; end
          CHECK: begin
            if (per == DIV) begin
              m_good++;
              if (m_good == LCK) m_state = LOCKED;
            end else m_good = 0;
          end
          default: begin
            if (per != DIV) begin x.err = 1'b1; m_state = CHECK; m_good = 0; end
          end
        endcase
        x.lock = (m_state == LOCKED);
        sq.push_back(x);
        last_e = e;
        have_last = 1'b1;
      end
    end
    last_d = d;
    last_r = r;
  endtask

  task automatic run_period(input int hi, input int p);
    for (int i = 0; i < p; i++) step(i < hi, 1'b0, 1'b0);
  endtask

  int exp_phase = 0;
  bit exp_lock = 1'b0;
  always @(posedge clk) begin
    bit   exp_err, exp_str;
    exp_t x;
    cyc = cyc + 1;
    rst_at_edge = in_rst;
    #2;
    if (rst_at_edge) begin
      exp_phase = 0;
      exp_lock  = 1'b0;
      chk("rst_strobe", strobe, 0);
      chk("rst_phase", phase, 0);
      chk("rst_period", period, 0);
      chk("rst_lock", lock, 0);
      chk("rst_err", err, 0);
    end else begin
      exp_err = 1'b0;
      exp_str = (sq.size() > 0) && (sq[0].due == cyc);
      chk("strobe", strobe, exp_str);
      if (exp_str) begin
        x = sq.pop_front();
        if (x.period >= 0) chk("period", period, x.period);
        exp_lock = x.lock;
        exp_err  = x.err;
      end
      if (tq.size() > 0 && tq[0].due == cyc) begin
        exp_lock = 1'b0;
        exp_err  = tq[0].err;
        void'(tq.pop_front());
      end
      chk("lock", lock, exp_lock);
      chk("err", err, exp_err);
      exp_phase = exp_str ? 0 : (exp_phase + 1) % DIV;
      chk("phase", phase, exp_phase);
      if (strobe) strobes++;
      if (err) err_pulses++;
    end
  end

  initial begin
    seg_t segs[6];
    int   e0, s0, s8;
    segs[0] = '{2, 4, 9, 1'b1, 1'b0};
    segs[1] = '{2, 5, 1, 1'b1, 1'b0};
    segs[2] = '{2, 4, 8, 1'b0, 1'b1};
    segs[3] = '{2, 4, 1, 1'b1, 1'b0};
    segs[4] = '{1, 4, 3, 1'b1, 1'b0};
    segs[5] = '{3, 4, 2, 1'b1, 1'b0};

    in_rst = 1'b1; div_in = 1'b0; div8 = 1'b0;
    repeat (3) step(1'b0, 1'b1, 1'b0);

    for (int s = 0; s < 6; s++) begin
      e0 = err_pulses;
      for (int k = 0; k < segs[s].reps; k++) run_period(segs[s].hi, segs[s].per);
      chk($sformatf("seg%0d_lock", s), lock, segs[s].lock);
      chk($sformatf("seg%0d_err_seen", s), (err_pulses - e0) > 0, segs[s].err);
    end

    // Divided clock stalls low while locked.
    e0 = err_pulses;
    repeat (20) step(1'b0, 1'b0, 1'b0);
    chk("stall_lock", lock, 0);
    chk("stall_err_pulses", err_pulses - e0, 1);
    chk("stall_state_hunt", int'(dut.state_q), int'(HUNT));
    repeat (9) run_period(2, 4);
    chk("stall_relock", lock, 1);

    // One-cycle reset while locked, then reacquire.
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("midrst_lock", lock, 0);
    chk("midrst_period", period, 0);
    chk("midrst_strobe", strobe, 0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    repeat (8) run_period(2, 4);
    chk("midrst_relock", lock, 1);

    // Input already high at reset release and held high.
    repeat (3) step(1'b1, 1'b1, 1'b0);
    s0 = strobes;
    e0 = err_pulses;
    repeat (20) step(1'b1, 1'b0, 1'b0);
    chk("hi_at_rel_strobes", strobes - s0, 1);
    chk("hi_at_rel_lock", lock, 0);
    chk("hi_at_rel_err", err_pulses - e0, 0);

    // Ratio 8 with alternating 8/7 periods never locks.
    s8 = 0;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < ((k % 2 == 0) ? 8 : 7); i++) begin
        step(1'b0, 1'b0, i < 4);
        chk("d8_lock", lock8, 0);
        chk("d8_err", err8, 0);
        chk("d8_good_le1", dut8.good_q > 4'd1, 0);
        if (strobe8) begin
          s8++;
          chk("d8_phase_at_strobe", phase8, 0);
          if (s8 > 1) chk("d8_period_7_or_8", (period8 == 5'd7) || (period8 == 5'd8), 1);
        end
      end
    end
    chk("d8_strobes_seen", s8 >= 15, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
